// File: rtl/spi_mst_mcs.sv
// rtl/spi_mst_mcs.sv - SPI master with TX/RX FIFOs and multiple chip selects
module spi_mst_mcs #(
  parameter int DW    = 16,
  parameter int DEPTH = 8,
  parameter int NCS   = 4,
  parameter int DIVW  = 8,
  localparam int CSW  = (NCS > 1) ? $clog2(NCS) : 1,
  localparam int AW   = $clog2(DEPTH),
  localparam int PW   = AW + 1,
  localparam int BW   = $clog2(DW)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_en,
  input  logic            cfg_cpol,
  input  logic            cfg_cpha,
  input  logic            cfg_lsbf,
  input  logic            cfg_cont,
  input  logic [DIVW-1:0] cfg_div,
  input  logic [CSW-1:0]  cfg_cs,
  input  logic            tx_valid,
  output logic            tx_ready,
  input  logic [DW-1:0]   tx_data,
  output logic            rx_valid,
  input  logic            rx_ready,
  output logic [DW-1:0]   rx_data,
  output logic [PW-1:0]   tx_level,
  output logic [PW-1:0]   rx_level,
  output logic            busy,
  output logic            sclk,
  output logic [NCS-1:0]  nss,
  output logic            mosi,
  input  logic            miso,
  output logic            irq_out
);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
  state_t state, next;

  logic [DW-1:0] tx_mem [DEPTH];
  logic [DW-1:0] rx_mem [DEPTH];
  logic [PW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic          tx_push, tx_pop, rx_push, rx_pop, start;

  logic            cpol_l, cpha_l, lsbf_l, cont_l, cs_ok_l, phase;
  logic [DIVW-1:0] div_l, cnt;
  logic [BW-1:0]   bitcnt;
  logic [DW-1:0]   tx_sr, rx_sr, tx_next, rx_next;
  logic [NCS-1:0]  cs_mask;
  logic            half_end, last_bit;

  // Pointers carry a wrap bit so full and empty are distinguishable.
  assign tx_full  = (tx_wp[AW-1:0] == tx_rp[AW-1:0]) && (tx_wp[AW] != tx_rp[AW]);
  assign tx_empty = (tx_wp == tx_rp);
  assign rx_full  = (rx_wp[AW-1:0] == rx_rp[AW-1:0]) && (rx_wp[AW] != rx_rp[AW]);
  assign rx_empty = (rx_wp == rx_rp);
  assign tx_ready = ~tx_full;
  assign tx_push  = tx_valid & ~tx_full;
  assign rx_valid = ~rx_empty;
  assign rx_pop   = rx_ready & ~rx_empty;
  assign rx_data  = rx_mem[rx_rp[AW-1:0]];
  assign tx_level = tx_wp - tx_rp;
  assign rx_level = rx_wp - rx_rp;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= tx_data;
    if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_sr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wp <= '0;
      tx_rp <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + PW'(1);
      if (tx_pop)  tx_rp <= tx_rp + PW'(1);
      if (rx_push) rx_wp <= rx_wp + PW'(1);
      if (rx_pop)  rx_rp <= rx_rp + PW'(1);
    end
  end

  always_comb begin
    cs_mask = '1;
    for (int i = 0; i < NCS; i++)
      if (int'(cfg_cs) == i) cs_mask[i] = 1'b0;
  end

  assign half_end = (cnt == div_l);
  assign last_bit = (bitcnt == BW'(DW - 1));
  assign tx_next  = lsbf_l ? (tx_sr >> 1) : (tx_sr << 1);
  assign rx_next  = lsbf_l ? {miso, rx_sr[DW-1:1]} : {rx_sr[DW-2:0], miso};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next    = state;
    tx_pop  = 1'b0;
    rx_push = 1'b0;
    start   = 1'b0;
    case (state)
      IDLE:
        if (cfg_en && !tx_empty && !rx_full) begin
          next   = SETUP;
          tx_pop = 1'b1;
          start  = 1'b1;
        end
      SETUP:
        if (half_end) next = SHIFT;
      SHIFT:
        if (half_end && phase && last_bit) begin
          next    = HOLD;
          rx_push = 1'b1;
        end
      HOLD:
        if (half_end) begin
          if (cont_l && cfg_en && !tx_empty && !rx_full) begin
            next   = SETUP;
            tx_pop = 1'b1;
          end else begin
            next = IDLE;
          end
        end
      default: next = IDLE;
    endcase
  end

  // phase 0 = first half of a bit period (after leading edge), 1 = after trailing edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpol_l  <= 1'b0;
      cpha_l  <= 1'b0;
      lsbf_l  <= 1'b0;
      cont_l  <= 1'b0;
      cs_ok_l <= 1'b0;
      div_l   <= '0;
      nss     <= '1;
      cnt     <= '0;
      phase   <= 1'b0;
      bitcnt  <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
    end else begin
      if (state == IDLE) cpol_l <= cfg_cpol;
      if (start) begin
        cpha_l  <= cfg_cpha;
        lsbf_l  <= cfg_lsbf;
        cont_l  <= cfg_cont;
        div_l   <= cfg_div;
        cs_ok_l <= (int'(cfg_cs) < NCS);
        nss     <= cs_mask;
      end
      if (tx_pop) tx_sr <= tx_mem[tx_rp[AW-1:0]];
      cnt <= (state == IDLE || half_end) ? '0 : cnt + DIVW'(1);
      if (state == SETUP && half_end) begin
        phase  <= 1'b0;
        bitcnt <= '0;
        if (!cpha_l) rx_sr <= rx_next;
      end
      if (state == SHIFT && half_end) begin
        phase <= ~phase;
        if (!phase) begin
          if (cpha_l) rx_sr <= rx_next;
          else        tx_sr <= tx_next;
        end else if (!last_bit) begin
          bitcnt <= bitcnt + BW'(1);
          if (cpha_l) tx_sr <= tx_next;
          else        rx_sr <= rx_next;
        end
      end
      if (state == HOLD && next == IDLE) nss <= '1;
    end
  end

  assign busy    = (state != IDLE);
  assign sclk    = (state == SHIFT && cs_ok_l) ? (cpol_l ^ ~phase) : cpol_l;
  assign mosi    = busy & (lsbf_l ? tx_sr[0] : tx_sr[DW-1]);
  assign irq_out = ~rst & (rx_valid | ((tx_level == '0) & ~busy & cfg_en));

endmodule
